// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL lock-qualified reset sequencer.
// The state encoding is fixed so debug probes and legacy decoders agree on it.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_STABLE = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_PLLRST = 3'd4
    } state_t;

    // The shared counter only ever reaches (largest phase length - 1).
    function automatic int cnt_width(input int stable_cycles,
                                     input int hold_cycles,
                                     input int timeout_cycles,
                                     input int pllrst_cycles);
        int m;
        m = stable_cycles;
        if (hold_cycles > m)    m = hold_cycles;
        if (timeout_cycles > m) m = timeout_cycles;
        if (pllrst_cycles > m)  m = pllrst_cycles;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// All stages load RESET_VAL under reset so the output starts in a known state.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Lock-qualified reset sequencer: releases downstream reset only after a stable
// PLL lock, re-asserts it on lock loss, and requests a PLL reset on lock timeout.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PLLRST_CYCLES  = 16,
    parameter int CNT_W          = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             lockedn,
    output logic             rst_out,
    output logic             rst_n_out,
    output logic             ready,
    output logic             pll_rst,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] relock_count
);

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES, PLLRST_CYCLES);

    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLLRST_CYCLES - 1);

    logic          lockedn_s;
    logic          lock_s;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          loss_inc, relock_inc;

    // Lock is held inactive (lockedn=1) until the synchronizer has real samples.
    sync_bit #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_lock_sync (
        .clk (CLK),
        .rst (RST),
        .d   (lockedn),
        .q   (lockedn_s)
    );

    assign lock_s = ~lockedn_s;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        loss_inc   = 1'b0;
        relock_inc = 1'b0;
        case (state)
            ST_WAIT: begin
                if (lock_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = ST_PLLRST;
                    cnt_next   = '0;
                    relock_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next = ST_WAIT;
                    loss_inc   = 1'b1;
                end
            end
            ST_PLLRST: begin
                // Lock is ignored here: the PLL is being reset regardless.
                if (cnt == PLLRST_LAST) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_WAIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_WAIT;
            cnt          <= '0;
            rst_out      <= 1'b1;
            ready        <= 1'b0;
            pll_rst      <= 1'b0;
            loss_count   <= '0;
            relock_count <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            rst_out <= (state_next != ST_RUN);
            ready   <= (state_next == ST_RUN);
            pll_rst <= (state_next == ST_PLLRST);
            if (loss_inc && (loss_count != '1)) begin
                loss_count <= loss_count + CNT_W'(1);
            end
            if (relock_inc && (relock_count != '1)) begin
                relock_count <= relock_count + CNT_W'(1);
            end
        end
    end

    assign rst_n_out = ~rst_out;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: stimulus queues expected outputs tagged with
// the edge after which they must hold; a negedge monitor pops and compares them.
module tb_pll_reset_seq;

    localparam int CNT_W = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             lockedn = 1'b1;
    logic             rst_out;
    logic             rst_n_out;
    logic             ready;
    logic             pll_rst;
    logic [CNT_W-1:0] loss_count;
    logic [CNT_W-1:0] relock_count;

    typedef struct {
        int    at;
        string name;
        logic  rst;
        logic  pll;
        int    loss;
        int    relock;
    } exp_t;

    exp_t sb_q[$];
    int   edge_no  = 0;
    int   checks   = 0;
    int   failures = 0;

    pll_reset_seq #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (8),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (20),
        .PLLRST_CYCLES  (4),
        .CNT_W          (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .lockedn      (lockedn),
        .rst_out      (rst_out),
        .rst_n_out    (rst_n_out),
        .ready        (ready),
        .pll_rst      (pll_rst),
        .loss_count   (loss_count),
        .relock_count (relock_count)
    );

    always #20 CLK = ~CLK;

    always @(posedge CLK) edge_no <= edge_no + 1;

    task automatic check(input exp_t e);
        logic ok;
        checks++;
        ok = (e.at == edge_no) &&
             (rst_out === e.rst) && (rst_n_out === ~e.rst) && (ready === ~e.rst) &&
             (pll_rst === e.pll) &&
             (loss_count === CNT_W'(e.loss)) && (relock_count === CNT_W'(e.relock));
        if (!ok) begin
            failures++;
            $display("FAIL %s edge=%0d/%0d got rst_out=%b rst_n_out=%b ready=%b pll_rst=%b loss=%0d relock=%0d want rst_out=%b rst_n_out=%b ready=%b pll_rst=%b loss=%0d relock=%0d",
                     e.name, edge_no, e.at, rst_out, rst_n_out, ready, pll_rst, loss_count, relock_count,
                     e.rst, ~e.rst, ~e.rst, e.pll, e.loss, e.relock);
        end
    endtask

    // Monitor: compare every expectation whose edge has been reached.
    always @(negedge CLK) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].at <= edge_no) begin
            e = sb_q.pop_front();
            check(e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Insert keeping the queue ordered by edge.
    task automatic expect_at(input int at, input string name, input logic r, input logic p,
                             input int loss, input int relock);
        exp_t e;
        int   idx;
        e.at = at; e.name = name; e.rst = r; e.pll = p; e.loss = loss; e.relock = relock;
        idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, e);
    endtask

    // Called at a negedge; RST is seen on the next n edges and dropped afterwards.
    task automatic do_reset(input int n, input string name);
        RST = 1'b1;
        expect_at(edge_no + 1, name, 1'b1, 1'b0, 0, 0);
        tick(n);
        RST = 1'b0;
    endtask

    initial begin : stim
        int base;
        @(negedge CLK);

        // Clean lock: lockedn=0 sampled on edge 1, reset released on edge 15.
        lockedn = 1'b1;
        do_reset(3, "reset_state");
        base = edge_no;
        lockedn = 1'b0;
        expect_at(base + 1,  "lock_e1",  1'b1, 1'b0, 0, 0);
        expect_at(base + 14, "lock_e14", 1'b1, 1'b0, 0, 0);
        expect_at(base + 15, "lock_e15", 1'b0, 1'b0, 0, 0);
        tick(16);

        // Lock loss in RUN, then relock.
        base = edge_no;
        lockedn = 1'b1;
        expect_at(base + 2, "loss_e2", 1'b0, 1'b0, 0, 0);
        expect_at(base + 3, "loss_e3", 1'b1, 1'b0, 1, 0);
        tick(5);
        base = edge_no;
        lockedn = 1'b0;
        expect_at(base + 14, "relock_e14", 1'b1, 1'b0, 1, 0);
        expect_at(base + 15, "relock_e15", 1'b0, 1'b0, 1, 0);
        tick(16);

        // One-cycle glitch in STABLE restarts the whole sequence, uncounted.
        do_reset(3, "rst_from_run");
        base = edge_no;
        lockedn = 1'b0;
        expect_at(base + 15, "glitch_e15", 1'b1, 1'b0, 0, 0);
        expect_at(base + 20, "glitch_e20", 1'b1, 1'b0, 0, 0);
        expect_at(base + 21, "glitch_e21", 1'b0, 1'b0, 0, 0);
        tick(5);
        lockedn = 1'b1;
        tick(1);
        lockedn = 1'b0;
        tick(16);

        // Timeout: PLL reset pulses after edges 20 and 44.
        lockedn = 1'b1;
        do_reset(3, "rst_to_timeout");
        base = edge_no;
        expect_at(base + 19, "to_e19", 1'b1, 1'b0, 0, 0);
        expect_at(base + 20, "to_e20", 1'b1, 1'b1, 0, 1);
        expect_at(base + 23, "to_e23", 1'b1, 1'b1, 0, 1);
        expect_at(base + 24, "to_e24", 1'b1, 1'b0, 0, 1);
        expect_at(base + 43, "to_e43", 1'b1, 1'b0, 0, 1);
        expect_at(base + 44, "to_e44", 1'b1, 1'b1, 0, 2);
        tick(45);

        // RST mid-PLLRST cuts the pulse and clears counters; timeout restarts from 0.
        do_reset(1, "rst_mid_pllrst");
        base = edge_no;
        expect_at(base + 19, "post_rst_e19", 1'b1, 1'b0, 0, 0);
        expect_at(base + 20, "post_rst_e20", 1'b1, 1'b1, 0, 1);
        tick(21);

        // Saturation: five lock losses with a 2-bit counter.
        do_reset(2, "rst_to_sat");
        for (int i = 0; i < 5; i++) begin
            base = edge_no;
            lockedn = 1'b0;
            expect_at(base + 15, $sformatf("sat_run_%0d", i),  1'b0, 1'b0, (i > 3) ? 3 : i, 0);
            expect_at(base + 19, $sformatf("sat_loss_%0d", i), 1'b1, 1'b0, (i + 1 > 3) ? 3 : i + 1, 0);
            tick(16);
            lockedn = 1'b1;
            tick(4);
        end

        // RST mid-HOLD, then a full sequence from WAIT.
        base = edge_no;
        lockedn = 1'b0;
        tick(12);
        do_reset(1, "rst_mid_hold");
        base = edge_no;
        expect_at(base + 14, "hold_rst_e14", 1'b1, 1'b0, 0, 0);
        expect_at(base + 15, "hold_rst_e15", 1'b0, 1'b0, 0, 0);
        tick(16);

        // lockedn toggling every cycle never reaches RUN.
        base = edge_no;
        expect_at(base + 2,  "tog_e2",  1'b0, 1'b0, 0, 0);
        expect_at(base + 3,  "tog_e3",  1'b1, 1'b0, 1, 0);
        expect_at(base + 12, "tog_e12", 1'b1, 1'b0, 1, 0);
        expect_at(base + 22, "tog_e22", 1'b1, 1'b0, 1, 0);
        expect_at(base + 31, "tog_e31", 1'b1, 1'b0, 1, 0);
        for (int i = 0; i < 31; i++) begin
            lockedn = ~lockedn;
            tick(1);
        end
        lockedn = 1'b1;

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick(1);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain pending=%0d want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
